// File: rtl/ift_monitor_pkg.sv
// Shared types for the memory-port taint monitor: FSM states and cause-bit positions.
package ift_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      TRIPPED = 2'd2
   } mon_state_e;

   localparam int unsigned NCause     = 4;
   localparam int unsigned CauseCtrl  = 0;
   localparam int unsigned CauseAddr  = 1;
   localparam int unsigned CauseWdata = 2;
   localparam int unsigned CauseStrb  = 3;

   typedef logic [NCause-1:0] cause_t;

endpackage

// File: rtl/ift_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module ift_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + 1'b1;
      end
   end

endmodule

// File: rtl/ift_mem_taint_monitor.sv
// Passive taint monitor for one memory port: flags tainted request control/address/strobe/data,
// latches the first event and keeps saturating event/cycle counters. Never touches the port.
module ift_mem_taint_monitor
   import ift_monitor_pkg::*;
#(
   parameter int unsigned CntW  = 32,
   parameter int unsigned AddrW = 32,
   parameter int unsigned DataW = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             arm_i,
   input  logic             clear_i,
   input  logic             req_i,
   input  logic             req_i_t0,
   input  logic             we_i,
   input  logic             we_i_t0,
   input  logic [AddrW-1:0] addr_i,
   input  logic [AddrW-1:0] addr_i_t0,
   input  logic [DataW-1:0] wdata_i,
   input  logic [DataW-1:0] wdata_i_t0,
   input  logic [DataW-1:0] strb_i,
   input  logic [DataW-1:0] strb_i_t0,
   output logic             armed_o,
   output logic             tripped_o,
   output logic             trip_pulse_o,
   output logic [3:0]       first_cause_o,
   output logic [AddrW-1:0] first_addr_o,
   output logic [CntW-1:0]  first_cycle_o,
   output logic [CntW-1:0]  evt_cnt_o,
   output logic [CntW-1:0]  store_evt_cnt_o,
   output logic [CntW-1:0]  cycle_cnt_o
);

   mon_state_e state_q, state_d;
   cause_t     cause;
   logic       evt;
   logic       is_store;
   logic       trip;
   logic       count_evt;

   // Data value is irrelevant to taint; only its shadow masked by the strobe matters.
   logic unused_wdata;
   assign unused_wdata = ^wdata_i;

   always_comb begin
      cause             = '0;
      cause[CauseCtrl]  = req_i_t0 | (req_i & we_i_t0);
      cause[CauseAddr]  = req_i & (|addr_i_t0);
      cause[CauseWdata] = req_i & we_i & (|(wdata_i_t0 & strb_i));
      cause[CauseStrb]  = req_i & we_i & (|strb_i_t0);
   end

   assign evt      = |cause;
   assign is_store = req_i & we_i;
   assign trip     = (state_q == ARMED) & evt & ~clear_i;
   assign count_evt = (state_q != IDLE) & evt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // clear_i dominates everything; combined with arm_i it re-arms from a clean slate.
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = arm_i ? ARMED : IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (arm_i) state_d = ARMED;
            ARMED:   if (evt)   state_d = TRIPPED;
            TRIPPED: state_d = TRIPPED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         trip_pulse_o  <= 1'b0;
         first_cause_o <= '0;
         first_addr_o  <= '0;
         first_cycle_o <= '0;
      end else begin
         trip_pulse_o <= trip;
         if (clear_i) begin
            first_cause_o <= '0;
            first_addr_o  <= '0;
            first_cycle_o <= '0;
         end else if (trip) begin
            first_cause_o <= cause;
            first_addr_o  <= addr_i;
            first_cycle_o <= cycle_cnt_o;
         end
      end
   end

   assign armed_o   = (state_q != IDLE);
   assign tripped_o = (state_q == TRIPPED);

   ift_sat_counter #(.W(CntW)) u_cycle_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (1'b1),
      .clr_i  (1'b0),
      .cnt_o  (cycle_cnt_o)
   );

   ift_sat_counter #(.W(CntW)) u_evt_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (count_evt),
      .clr_i  (clear_i),
      .cnt_o  (evt_cnt_o)
   );

   ift_sat_counter #(.W(CntW)) u_store_evt_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (count_evt & is_store),
      .clr_i  (clear_i),
      .cnt_o  (store_evt_cnt_o)
   );

endmodule
